// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package mem_pkg;

  // Load/store width encodings carried in instruction[14:12]
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } mau_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, legality/alignment decode, and load extraction.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        load_legal,
  output logic        store_legal,
  output logic        aligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Issue side: strobes, replicated data and legality for the incoming access
  always_comb begin
    wstrb       = 4'b0000;
    wdata       = store_data;
    aligned     = 1'b0;
    load_legal  = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    store_legal = funct3 inside {F3_B, F3_H, F3_W};
    case (funct3[1:0])
      2'd0: begin
        wstrb   = 4'b0001 << off;
        wdata   = {4{store_data[7:0]}};
        aligned = 1'b1;
      end
      2'd1: begin
        wstrb   = off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{store_data[15:0]}};
        aligned = ~off[0];
      end
      2'd2: begin
        wstrb   = 4'b1111;
        wdata   = store_data;
        aligned = (off == 2'b00);
      end
      default: begin
        wstrb   = 4'b0000;
        wdata   = store_data;
        aligned = 1'b0;
      end
    endcase
  end

  // Response side: pick the addressed lane from the returned word and extend it
  always_comb begin
    rd_byte = rdata[{rsp_off, 3'b000} +: 8];
    rd_half = rsp_off[1] ? rdata[31:16] : rdata[15:0];
    case (rsp_funct3)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_data = {24'd0, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_data = {16'd0, rd_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage unit: runs one valid/ready data-memory transaction per load/store and
// stalls the pipeline until it completes, times out, or is rejected as a fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] instruction_in,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        fault_out,
  output logic        bus_error_out
);

  mau_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:2]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [31:0]      load_data_q;
  logic             load_valid_q;
  logic             fault_q;
  logic             bus_error_q;

  logic [2:0]  funct3;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_load_legal;
  logic        al_store_legal;
  logic        al_aligned;
  logic        access;
  logic        ok_issue;
  logic        bad_issue;
  logic        timeout_hit;
  logic        unused_instr;

  assign funct3       = instruction_in[14:12];
  assign unused_instr = ^{instruction_in[31:15], instruction_in[11:0]};

  lsu_align u_align (
    .funct3      (funct3),
    .off         (addr_in[1:0]),
    .store_data  (store_data_in),
    .rsp_funct3  (funct3_q),
    .rsp_off     (off_q),
    .rdata       (mem_rsp_rdata),
    .wstrb       (al_wstrb),
    .wdata       (al_wdata),
    .load_data   (al_load_data),
    .load_legal  (al_load_legal),
    .store_legal (al_store_legal),
    .aligned     (al_aligned)
  );

  // Issue decode, timeout detect and the combinational stall
  always_comb begin
    access      = load_in ^ store_in;
    ok_issue    = access && al_aligned && (load_in ? al_load_legal : al_store_legal);
    bad_issue   = (load_in && store_in) || (access && !ok_issue);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    stall_out   = ((state_q == IDLE) && ok_issue) || (state_q == REQ) || (state_q == RSP);
  end

  // Transaction FSM with registered pulses and latched request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      we_q         <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ok_issue) begin
            addr_q   <= addr_in[31:2];
            wdata_q  <= al_wdata;
            wstrb_q  <= store_in ? al_wstrb : 4'b0000;
            funct3_q <= funct3;
            off_q    <= addr_in[1:0];
            we_q     <= store_in;
            cnt_q    <= '0;
            state_q  <= REQ;
          end else if (bad_issue) begin
            fault_q <= 1'b1;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // Acceptance takes priority over a coincident timeout
          if (mem_req_ready) begin
            state_q <= we_q ? DONE : RSP;
          end else if (timeout_hit) begin
            bus_error_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        RSP: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rsp_valid) begin
            load_data_q  <= al_load_data;
            load_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (timeout_hit) begin
            bus_error_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        // One idle beat so the same EX/MEM entry is not issued twice
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_we     = we_q;
  assign mem_req_addr   = {addr_q, 2'b00};
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign fault_out      = fault_q;
  assign bus_error_out  = bus_error_q;

endmodule
